mc_control_fsm: RTL and testbench

Parametrised multi-cycle control unit for the MIPS-subset multi-cycle CPU. It generates every datapath control strobe from the instruction-register opcode and funct fields. Unlike the fixed-latency controller, it accepts a memory ready handshake with variable wait states, traps on illegal opcodes and on memory timeouts, and can optionally count cycles and retired instructions. It sits beside the PC, IR, register file and ALU in the CPU top level.

---
 rtl/mc_ctrl_pkg.sv | 78 +++++++
 rtl/mc_control_fsm_if.sv | 45 ++++
 rtl/mc_mem_watchdog.sv | 37 +++
 rtl/mc_control_fsm.sv | 238 +++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: state encoding,
// ALU operation codes, opcode/funct values, trap causes and the datapath strobe bundle.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF,
    S_ID,
    S_EX_R,
    S_WB_R,
    S_EX_I,
    S_WB_I,
    S_LUI,
    S_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BR,
    S_J,
    S_JAL,
    S_JR,
    S_JALR,
    S_TRAP
  } state_e;

  localparam int unsigned ALU_ADD   = 0;
  localparam int unsigned ALU_SUB   = 1;
  localparam int unsigned ALU_RTYPE = 2;
  localparam int unsigned ALU_AND   = 3;
  localparam int unsigned ALU_OR    = 4;
  localparam int unsigned ALU_SLT   = 5;
  localparam int unsigned ALU_SLTU  = 6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic [1:0] {
    CAUSE_NONE        = 2'b00,
    CAUSE_ILLEGAL     = 2'b01,
    CAUSE_MEM_TIMEOUT = 2'b10
  } trap_cause_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] reg_dst;
    logic [1:0] memto_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
  } strobes_t;

  // States in which the controller is waiting on the memory handshake.
  function automatic logic is_mem_wait_state(state_e s);
    return (s == S_IF) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle controller (master) and the datapath (slave):
// IR fields and memory handshake in, every datapath strobe plus trap status out.
interface mc_control_fsm_if
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
);

  logic [5:0]         OpCode;
  logic [5:0]         Funct;
  logic               mem_ready;

  logic               PCWrite;
  logic               PCWriteCond;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               ExtOp;
  logic               LuiOp;
  logic [1:0]         RegDst;
  logic [1:0]         MemtoReg;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic [1:0]         PCSource;
  logic               trap;
  trap_cause_e        trap_cause;

  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ExtOp, LuiOp, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           trap, trap_cause
  );

  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
           ExtOp, LuiOp, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           trap, trap_cause
  );

endinterface

// File: rtl/mc_mem_watchdog.sv
// Memory wait-state watchdog: counts consecutive not-ready cycles of one access and
// flags a timeout on the MEM_WAIT_MAX-th such cycle.
module mc_mem_watchdog #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wait_i,
  input  logic ready_i,
  input  logic clear_i,
  output logic timeout_o
);

  localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A ready in the limit cycle is a completion, so the timeout requires ready low.
  assign timeout_o = wait_i & ~ready_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!wait_i || ready_i || clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset control unit with memory handshake, illegal-opcode and
// memory-timeout traps. Optional performance counters under `define MC_PERF_CNT_EN.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W      = 4,
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_fsm_if.master bus
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  if (ALUOP_W < 3) begin : g_bad_aluop_w
    $error("ALUOP_W must be at least 3");
  end
  if (MEM_WAIT_MAX < 1) begin : g_bad_wait_max
    $error("MEM_WAIT_MAX must be at least 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  state_e             state_q, state_d;
  trap_cause_e        cause_q, cause_d;
  strobes_t           str;
  logic [ALUOP_W-1:0] alu_op;
  logic               mem_wait;
  logic               timeout;
  logic               state_change;

  assign mem_wait     = is_mem_wait_state(state_q);
  assign state_change = (state_d != state_q);

  mc_mem_watchdog #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wdog (
    .clk_i    (clk),
    .rst_ni   (reset),
    .wait_i   (mem_wait),
    .ready_i  (bus.mem_ready),
    .clear_i  (state_change),
    .timeout_o(timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    str     = '0;
    alu_op  = ALUOP_W'(ALU_ADD);
    case (state_q)
      S_IF: begin
        str.mem_read  = 1'b1;
        str.alu_src_b = 2'b01;
        str.pc_write  = bus.mem_ready;
        str.ir_write  = bus.mem_ready;
        if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end else if (bus.mem_ready) begin
          state_d = S_ID;
        end
      end
      S_ID: begin
        str.alu_src_b = 2'b11;
        str.ext_op    = 1'b1;
        case (bus.OpCode)
          OP_RTYPE: begin
            case (bus.Funct)
              FN_JR:   state_d = S_JR;
              FN_JALR: state_d = S_JALR;
              default: state_d = S_EX_R;
            endcase
          end
          OP_LW, OP_SW: state_d = S_ADDR;
          OP_BEQ:       state_d = S_BR;
          OP_J:         state_d = S_J;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI: state_d = S_EX_I;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EX_R: begin
        str.alu_src_a = 2'b01;
        alu_op        = ALUOP_W'(ALU_RTYPE);
        state_d       = S_WB_R;
      end
      S_WB_R: begin
        str.reg_dst   = 2'b01;
        str.memto_reg = 2'b01;
        str.reg_write = 1'b1;
        state_d       = S_IF;
      end
      S_EX_I: begin
        str.alu_src_a = 2'b01;
        str.alu_src_b = 2'b10;
        str.ext_op    = (bus.OpCode != OP_ANDI) && (bus.OpCode != OP_ORI);
        case (bus.OpCode)
          OP_SLTI:  alu_op = ALUOP_W'(ALU_SLT);
          OP_SLTIU: alu_op = ALUOP_W'(ALU_SLTU);
          OP_ANDI:  alu_op = ALUOP_W'(ALU_AND);
          OP_ORI:   alu_op = ALUOP_W'(ALU_OR);
          default:  alu_op = ALUOP_W'(ALU_ADD);
        endcase
        state_d = S_WB_I;
      end
      S_WB_I: begin
        str.memto_reg = 2'b01;
        str.reg_write = 1'b1;
        state_d       = S_IF;
      end
      S_LUI: begin
        str.lui_op    = 1'b1;
        str.memto_reg = 2'b11;
        str.reg_write = 1'b1;
        state_d       = S_IF;
      end
      S_ADDR: begin
        str.alu_src_a = 2'b01;
        str.alu_src_b = 2'b10;
        str.ext_op    = 1'b1;
        state_d       = (bus.OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        str.iord     = 1'b1;
        str.mem_read = 1'b1;
        if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end else if (bus.mem_ready) begin
          state_d = S_WB_MEM;
        end
      end
      S_WB_MEM: begin
        str.reg_write = 1'b1;
        state_d       = S_IF;
      end
      S_MEM_WR: begin
        str.iord      = 1'b1;
        str.mem_write = 1'b1;
        if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEM_TIMEOUT;
        end else if (bus.mem_ready) begin
          state_d = S_IF;
        end
      end
      S_BR: begin
        str.alu_src_a     = 2'b01;
        str.pc_write_cond = 1'b1;
        str.pc_source     = 2'b01;
        alu_op            = ALUOP_W'(ALU_SUB);
        state_d           = S_IF;
      end
      S_J, S_JR: begin
        str.pc_write  = 1'b1;
        str.pc_source = 2'b10;
        state_d       = S_IF;
      end
      S_JAL, S_JALR: begin
        str.pc_write  = 1'b1;
        str.pc_source = 2'b10;
        str.reg_write = 1'b1;
        str.reg_dst   = (state_q == S_JAL) ? 2'b10 : 2'b01;
        str.memto_reg = 2'b10;
        state_d       = S_IF;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // Outputs are forced low while reset is held, which also kills any in-flight write.
  assign bus.PCWrite     = reset & str.pc_write;
  assign bus.PCWriteCond = reset & str.pc_write_cond;
  assign bus.IorD        = reset & str.iord;
  assign bus.MemRead     = reset & str.mem_read;
  assign bus.MemWrite    = reset & str.mem_write;
  assign bus.IRWrite     = reset & str.ir_write;
  assign bus.RegWrite    = reset & str.reg_write;
  assign bus.ExtOp       = reset & str.ext_op;
  assign bus.LuiOp       = reset & str.lui_op;
  assign bus.RegDst      = reset ? str.reg_dst   : 2'b00;
  assign bus.MemtoReg    = reset ? str.memto_reg : 2'b00;
  assign bus.ALUSrcA     = reset ? str.alu_src_a : 2'b00;
  assign bus.ALUSrcB     = reset ? str.alu_src_b : 2'b00;
  assign bus.PCSource    = reset ? str.pc_source : 2'b00;
  assign bus.ALUOp       = reset ? alu_op : '0;
  assign bus.trap        = reset & (state_q == S_TRAP);
  assign bus.trap_cause  = reset ? cause_q : CAUSE_NONE;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instr_q;

  // An instruction retires on every re-entry into fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state_q != S_TRAP) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if ((state_d == S_IF) && (state_q != S_IF)) begin
        instr_q <= instr_q + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: a per-instruction reference model queues the
// expected strobe word for every cycle, a negedge monitor pops and compares.
module tb_mc_control_fsm;

  localparam int MAXW = 4;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regWrite;
    logic       extOp;
    logic       luiOp;
    logic [1:0] regDst;
    logic [1:0] memtoReg;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [3:0] aluOp;
    logic [1:0] pcSource;
    logic       trap;
    logic [1:0] trapCause;
  } ctrl_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   monOn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  ctrl_t expQ[$];
  ctrl_t planW[$];
  bit    planR[$];

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycleCnt;
  logic [31:0] instrCnt;
`endif

  mc_control_fsm_if #(.ALUOP_W(4)) bus ();

  mc_control_fsm #(
    .ALUOP_W     (4),
    .MEM_WAIT_MAX(MAXW),
    .CNT_W       (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt(cycleCnt),
    .instr_cnt(instrCnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL globalTimeout got=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  function automatic ctrl_t sampleDut();
    ctrl_t w;
    w.pcWrite     = bus.PCWrite;
    w.pcWriteCond = bus.PCWriteCond;
    w.iorD        = bus.IorD;
    w.memRead     = bus.MemRead;
    w.memWrite    = bus.MemWrite;
    w.irWrite     = bus.IRWrite;
    w.regWrite    = bus.RegWrite;
    w.extOp       = bus.ExtOp;
    w.luiOp       = bus.LuiOp;
    w.regDst      = bus.RegDst;
    w.memtoReg    = bus.MemtoReg;
    w.aluSrcA     = bus.ALUSrcA;
    w.aluSrcB     = bus.ALUSrcB;
    w.aluOp       = bus.ALUOp;
    w.pcSource    = bus.PCSource;
    w.trap        = bus.trap;
    w.trapCause   = bus.trap_cause;
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every cycle in reset must be all-zero, otherwise the next queued word applies.
  always @(negedge clk) begin
    if (monOn) begin
      cyc++;
      if (!reset) begin
        checkOutput("resetForcesZero", 64'(sampleDut()), 64'd0);
      end else if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboardUnderflow cycle=%0d got=%h required=queued word", cyc, sampleDut());
      end else begin
        checkOutput("ctrlWord", 64'(sampleDut()), 64'(expQ.pop_front()));
      end
    end
  end

  function automatic bit rndBit();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic ctrl_t fetchWord(bit rdy);
    ctrl_t w = '0;
    w.memRead = 1'b1;
    w.aluSrcB = 2'b01;
    w.pcWrite = rdy;
    w.irWrite = rdy;
    return w;
  endfunction

  task automatic addStep(input ctrl_t w, input bit rdy);
    planW.push_back(w);
    planR.push_back(rdy);
  endtask

  task automatic addTrap(input logic [1:0] cause);
    ctrl_t w = '0;
    w.trap      = 1'b1;
    w.trapCause = cause;
    for (int i = 0; i < 4; i++) addStep(w, rndBit());
  endtask

  // Reference model: the full cycle-by-cycle strobe sequence of one instruction.
  task automatic buildPlan(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    ctrl_t w;
    planW.delete();
    planR.delete();
    if (fw >= MAXW) begin
      for (int i = 0; i < MAXW; i++) addStep(fetchWord(1'b0), 1'b0);
      addTrap(2'b10);
      return;
    end
    for (int i = 0; i < fw; i++) addStep(fetchWord(1'b0), 1'b0);
    addStep(fetchWord(1'b1), 1'b1);
    w = '0; w.aluSrcB = 2'b11; w.extOp = 1'b1;
    addStep(w, rndBit());
    if (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)) begin
      w = '0; w.pcWrite = 1'b1; w.pcSource = 2'b10;
      if (fn == 6'h09) begin
        w.regWrite = 1'b1; w.regDst = 2'b01; w.memtoReg = 2'b10;
      end
      addStep(w, rndBit());
    end else if (op == 6'h00) begin
      w = '0; w.aluSrcA = 2'b01; w.aluSrcB = 2'b00; w.aluOp = 4'd2;
      addStep(w, rndBit());
      w = '0; w.regDst = 2'b01; w.memtoReg = 2'b01; w.regWrite = 1'b1;
      addStep(w, rndBit());
    end else if (op == 6'h02 || op == 6'h03) begin
      w = '0; w.pcWrite = 1'b1; w.pcSource = 2'b10;
      if (op == 6'h03) begin
        w.regWrite = 1'b1; w.regDst = 2'b10; w.memtoReg = 2'b10;
      end
      addStep(w, rndBit());
    end else if (op == 6'h04) begin
      w = '0; w.aluSrcA = 2'b01; w.aluOp = 4'd1; w.pcWriteCond = 1'b1; w.pcSource = 2'b01;
      addStep(w, rndBit());
    end else if (op == 6'h0F) begin
      w = '0; w.luiOp = 1'b1; w.memtoReg = 2'b11; w.regWrite = 1'b1;
      addStep(w, rndBit());
    end else if (op >= 6'h08 && op <= 6'h0D) begin
      w = '0; w.aluSrcA = 2'b01; w.aluSrcB = 2'b10;
      w.extOp = (op != 6'h0C && op != 6'h0D);
      case (op)
        6'h0A:   w.aluOp = 4'd5;
        6'h0B:   w.aluOp = 4'd6;
        6'h0C:   w.aluOp = 4'd3;
        6'h0D:   w.aluOp = 4'd4;
        default: w.aluOp = 4'd0;
      endcase
      addStep(w, rndBit());
      w = '0; w.memtoReg = 2'b01; w.regWrite = 1'b1;
      addStep(w, rndBit());
    end else if (op == 6'h23 || op == 6'h2B) begin
      w = '0; w.aluSrcA = 2'b01; w.aluSrcB = 2'b10; w.extOp = 1'b1;
      addStep(w, rndBit());
      w = '0; w.iorD = 1'b1;
      if (op == 6'h23) w.memRead = 1'b1;
      else             w.memWrite = 1'b1;
      if (mw >= MAXW) begin
        for (int i = 0; i < MAXW; i++) addStep(w, 1'b0);
        addTrap(2'b10);
        return;
      end
      for (int i = 0; i < mw; i++) addStep(w, 1'b0);
      addStep(w, 1'b1);
      if (op == 6'h23) begin
        w = '0; w.regWrite = 1'b1;
        addStep(w, rndBit());
      end
    end else begin
      addTrap(2'b01);
    end
  endtask

  // Queue the expected words, then drive mem_ready for exactly those cycles.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input int fw, input int mw, input int maxCycles);
    int n;
    buildPlan(op, fn, fw, mw);
    n = (planW.size() < maxCycles) ? planW.size() : maxCycles;
    for (int i = 0; i < n; i++) expQ.push_back(planW[i]);
    bus.OpCode = op;
    bus.Funct  = fn;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = planR[i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input int cycles);
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0] legalOps [13] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h0F,
                                  6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D};
    logic [5:0] op;
    logic [5:0] fn;
    bus.OpCode    = 6'h23;
    bus.Funct     = 6'h00;
    bus.mem_ready = 1'b1;
    monOn         = 1'b1;
    $display("[TB] start, MEM_WAIT_MAX=%0d", MAXW);
    doReset(3);

    applyStimulus(6'h23, 6'h00, 0, 0, 1000);
    applyStimulus(6'h2B, 6'h00, 0, 3, 1000);
    applyStimulus(6'h03, 6'h00, 0, 0, 1000);
    applyStimulus(6'h00, 6'h09, 0, 0, 1000);
    applyStimulus(6'h23, 6'h00, 3, 3, 1000);
    applyStimulus(6'h00, 6'h08, 1, 0, 1000);

    for (int k = 0; k < 60; k++) begin
      op = legalOps[$urandom_range(0, 12)];
      case ($urandom_range(0, 3))
        0:       fn = 6'h08;
        1:       fn = 6'h09;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      applyStimulus(op, fn, $urandom_range(0, MAXW - 1), $urandom_range(0, MAXW - 1), 1000);
    end

    $display("[TB] illegal opcode trap");
    applyStimulus(6'h3F, 6'h00, 0, 0, 1000);
    doReset(2);
    $display("[TB] fetch timeout trap");
    applyStimulus(6'h00, 6'h20, MAXW, 0, 1000);
    doReset(2);
    $display("[TB] load timeout trap");
    applyStimulus(6'h23, 6'h00, 0, MAXW, 1000);
    doReset(2);
    $display("[TB] store aborted by reset");
    applyStimulus(6'h2B, 6'h00, 0, 3, 4);
    doReset(2);
    applyStimulus(6'h04, 6'h00, 0, 0, 1000);

`ifdef MC_PERF_CNT_EN
    doReset(2);
    for (int k = 0; k < 10; k++) applyStimulus(6'h00, 6'h20, 0, 0, 1000);
    checkOutput("instrCnt", 64'(instrCnt), 64'd10);
    checkOutput("cycleCnt", 64'(cycleCnt), 64'd40);
`endif

    monOn = 1'b0;
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
